// File: rtl/global_types.sv
// Shared types for the multiply/divide unit: op encodings, FSM states, iteration count.
package global_types;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } muldiv_state_t;

   localparam logic [5:0] MULDIV_ITER = 6'd32;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between a pipeline front end (master) and muldiv_unit (slave).
interface muldiv_unit_if;

   logic                   start;
   global_types::muldiv_op_t op;
   logic [31:0]            a;
   logic [31:0]            b;
   logic                   flush;
   logic                   busy;
   logic                   done;
   logic [31:0]            hi;
   logic [31:0]            lo;
   logic                   div_by_zero;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo, div_by_zero
   );

endinterface

// File: rtl/d_en_reg.sv
// Enabled D register with asynchronous active-low clear.
module d_en_reg #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 64-bit accumulator.
// A single 33-bit adder serves both: add multiplicand, or subtract divisor.
module muldiv_step (
   input  logic [63:0] i_acc,
   input  logic [31:0] i_opd,
   input  logic        i_div,
   output logic [63:0] o_acc
);

   logic [32:0] w_x;
   logic [32:0] w_y;
   logic [32:0] w_sum;

   // Divide trials the left-shifted upper half, so it needs the 33rd bit from acc[63].
   assign w_x   = i_div ? i_acc[63:31] : {1'b0, i_acc[63:32]};
   assign w_y   = i_div ? ~{1'b0, i_opd} : (i_acc[0] ? {1'b0, i_opd} : 33'd0);
   assign w_sum = w_x + w_y + {32'd0, i_div};

   always_comb begin
      o_acc = {i_acc[62:0], 1'b0};
      if (!i_div)          o_acc = {w_sum, i_acc[31:1]};
      else if (!w_sum[32]) o_acc = {w_sum[31:0], i_acc[30:0], 1'b1};
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO result registers.
// Define MULDIV_SIGNED_EN to support signed MULT/DIV; otherwise op[0] is ignored.
module muldiv_unit
   import global_types::*;
(
   input  logic         clock,
   input  logic         reset_n,
   muldiv_unit_if.slave bus
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_FIN  = ST_FIN;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opd;
   logic        r_div;
   logic        r_dz;
   logic        r_done;
   logic        r_dbz;

   logic [63:0] w_step;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_hi;
   logic [31:0] w_lo;
   logic [31:0] w_hi_q;
   logic [31:0] w_lo_q;
   logic        w_div;
   logic        w_dz;
   logic        w_accept;
   logic        w_wr;

   assign w_div    = bus.op[1];
   assign w_dz     = w_div && (bus.b == 32'd0);
   assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
   assign w_wr     = (r_state == S_FIN) && !bus.flush;

`ifdef MULDIV_SIGNED_EN
   logic        w_sgn;
   logic        r_neg_p;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] w_res;

   assign w_sgn   = !bus.op[0];
   assign w_a_mag = (w_sgn && bus.a[31]) ? -bus.a : bus.a;
   assign w_b_mag = (w_sgn && bus.b[31]) ? -bus.b : bus.b;

   // Sign fix-ups are decided at accept; divide-by-zero results bypass them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_neg_p <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_p <= w_sgn && !w_div && (bus.a[31] ^ bus.b[31]);
         r_neg_q <= w_sgn && w_div && !w_dz && (bus.a[31] ^ bus.b[31]);
         r_neg_r <= w_sgn && w_div && !w_dz && bus.a[31];
      end
   end

   assign w_res = r_neg_p ? -r_acc : r_acc;
   assign w_hi  = r_neg_r ? -w_res[63:32] : w_res[63:32];
   assign w_lo  = r_neg_q ? -w_res[31:0]  : w_res[31:0];
`else
   assign w_a_mag = bus.a;
   assign w_b_mag = bus.b;
   assign w_hi    = r_acc[63:32];
   assign w_lo    = r_acc[31:0];
`endif

   muldiv_step u_step (
      .i_acc (r_acc),
      .i_opd (r_opd),
      .i_div (r_div),
      .o_acc (w_step)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_acc   <= 64'd0;
         r_opd   <= 32'd0;
         r_div   <= 1'b0;
         r_dz    <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (w_accept) begin
               // Multiplier sits in acc[31:0]; dividend likewise. Div-by-zero preloads its result.
               r_div   <= w_div;
               r_dz    <= w_dz;
               r_dbz   <= 1'b0;
               r_cnt   <= MULDIV_ITER;
               r_opd   <= w_div ? w_b_mag : w_a_mag;
               r_acc   <= w_dz ? {bus.a, 32'hFFFF_FFFF} : {32'd0, (w_div ? w_a_mag : w_b_mag)};
               r_state <= w_dz ? S_FIN : S_RUN;
            end
            S_RUN: begin
               r_acc <= w_step;
               r_cnt <= r_cnt - 6'd1;
               if (r_cnt == 6'd1) r_state <= S_FIN;
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
               if (r_dz) r_dbz <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   d_en_reg #(.WIDTH(32)) u_hi (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_en    (w_wr),
      .i_d     (w_hi),
      .o_q     (w_hi_q)
   );

   d_en_reg #(.WIDTH(32)) u_lo (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_en    (w_wr),
      .i_d     (w_lo),
      .o_q     (w_lo_q)
   );

   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = w_hi_q;
   assign bus.lo          = w_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; expected values are hand-computed constants.
module tb_muldiv_unit;
   import global_types::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   muldiv_unit_if u_if ();

   muldiv_unit u_dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (u_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Launch one op; lat counts edges from the accepting edge (=1) up to the edge that raises done.
   // poke_s re-pulses start mid-flight, poke_f pulses flush; limit bounds the wait.
   task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int poke_s, input int poke_f, input int limit, output int lat);
      @(negedge clk);
      u_if.op    = op;
      u_if.a     = a;
      u_if.b     = b;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      lat        = 1;
      u_if.start = 1'b0;
      chk("busy_acc", 64'(u_if.busy), 64'd1);
      while (!u_if.done && lat < limit) begin
         if (lat == poke_s) begin
            u_if.start = 1'b1;
            u_if.op    = OP_DIV;
            u_if.a     = 32'd9;
            u_if.b     = 32'd0;
         end
         if (lat == poke_f) u_if.flush = 1'b1;
         @(posedge clk); #1;
         lat++;
         u_if.start = 1'b0;
         u_if.flush = 1'b0;
      end
   endtask

   task automatic op_chk(input string tag, input muldiv_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz, input int poke_s);
      int lat;
      run_op(op, a, b, poke_s, 0, 60, lat);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_hi"}, 64'(u_if.hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(u_if.lo), 64'(elo));
      chk({tag, "_dbz"}, 64'(u_if.div_by_zero), 64'(edbz));
   endtask

   initial begin
      int lat;
      int nd;
      u_if.start = 1'b0;
      u_if.flush = 1'b0;
      u_if.op    = OP_MULTU;
      u_if.a     = 32'd0;
      u_if.b     = 32'd0;

      #12;
      chk("rst_hi",   64'(u_if.hi), 64'd0);
      chk("rst_lo",   64'(u_if.lo), 64'd0);
      chk("rst_busy", 64'(u_if.busy), 64'd0);
      chk("rst_done", 64'(u_if.done), 64'd0);
      chk("rst_dbz",  64'(u_if.div_by_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op_chk("multu_max2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 34, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
      @(posedge clk); #1;
      chk("done_pulse", 64'(u_if.done), 64'd0);
      chk("idle_busy",  64'(u_if.busy), 64'd0);

      op_chk("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 0);
      op_chk("div_5_0",    OP_DIV,  32'd5,   32'd0, 2,  32'd5, 32'hFFFF_FFFF, 1'b1, 0);
      // Issued in the done cycle of the previous op: back-to-back, clears the sticky flag.
      op_chk("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 34, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
      op_chk("multu_maxmax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
      op_chk("divu_7_100", OP_DIVU, 32'd7, 32'd100, 34, 32'd7, 32'd0, 1'b0, 0);

`ifdef MULDIV_SIGNED_EN
      op_chk("mult_m3_4",  OP_MULT, 32'hFFFF_FFFD, 32'd4, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 0);
      op_chk("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      op_chk("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0, 0);
`else
      op_chk("mult_m3_4",  OP_MULT, 32'hFFFF_FFFD, 32'd4, 34, 32'd3, 32'hFFFF_FFF4, 1'b0, 0);
      op_chk("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 34, 32'd1, 32'h7FFF_FFFC, 1'b0, 0);
      op_chk("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0, 0);
`endif
      op_chk("div_neg_0",  OP_DIV,  32'hFFFF_FFF0, 32'd0, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0);

      // A DIV-by-zero start pulsed mid-flight must be dropped, not queued.
      op_chk("multu_poke", OP_MULTU, 32'd3, 32'd5, 34, 32'd0, 32'd15, 1'b0, 5);
      @(posedge clk); #1;
      chk("poke_noqueue", 64'(u_if.busy), 64'd0);

      run_op(OP_MULTU, 32'd6, 32'd7, 0, 10, 11, lat);
      chk("flush_lat",  64'(lat), 64'd11);
      chk("flush_done", 64'(u_if.done), 64'd0);
      chk("flush_busy", 64'(u_if.busy), 64'd0);
      chk("flush_hi",   64'(u_if.hi), 64'd0);
      chk("flush_lo",   64'(u_if.lo), 64'd15);
      op_chk("after_flush", OP_MULTU, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0, 0);

      @(negedge clk);
      u_if.op    = OP_MULTU;
      u_if.start = 1'b1;
      u_if.flush = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      u_if.flush = 1'b0;
      chk("flush_prio_busy", 64'(u_if.busy), 64'd0);
      chk("flush_prio_lo",   64'(u_if.lo), 64'd42);

      run_op(OP_MULTU, 32'd6, 32'd9, 0, 0, 10, lat);
      chk("midrun_lat", 64'(lat), 64'd10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hi",   64'(u_if.hi), 64'd0);
      chk("arst_lo",   64'(u_if.lo), 64'd0);
      chk("arst_busy", 64'(u_if.busy), 64'd0);
      chk("arst_done", 64'(u_if.done), 64'd0);
      chk("arst_dbz",  64'(u_if.div_by_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (u_if.done) nd++;
      end
      chk("arst_nodone", 64'(nd), 64'd0);
      chk("arst_idle",   64'(u_if.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  operand A (rs), the dividend for DIV/DIVU.
REQ-007 b  input  32  operand B (rt), the divisor for DIV/DIVU.
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 busy  output  1  high while an operation is in flight (states RUN and FIN).
REQ-010 done  output  1  one-cycle pulse in the cycle hi/lo take new results.
REQ-011 hi  output  32  HI register: product upper half, or remainder.
REQ-012 lo  output  32  LO register: product lower half, or quotient.
REQ-013 div_by_zero  output  1  sticky flag; set when the last DIV/DIVU had b == 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, FIN.
REQ-015 In IDLE, start=1 with flush=0 SHALL latch a, b and op, load the 6-bit iteration counter with 32, clear div_by_zero, and go to RUN.
REQ-016 While busy, start SHALL be ignored, with no queuing.
REQ-017 Multiply SHALL use shift-add, one bit per cycle, into a 64-bit accumulator.
REQ-018 Divide SHALL use restoring division, one quotient bit per cycle.
REQ-019 RUN SHALL decrement the counter each cycle and go to FIN when the counter reaches 0.
REQ-020 FIN SHALL last one cycle: it writes hi/lo, asserts done, and returns to IDLE.
REQ-021 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+33, with hi/lo valid from then on.
REQ-022 For DIV/DIVU with b == 0, the block SHALL skip RUN and go straight to FIN.
REQ-023 In that case it SHALL set hi = a, lo = 32'hFFFF_FFFF and div_by_zero = 1, with done in the cycle after edge N+1.
REQ-024 hi and lo SHALL change only in FIN; between operations they hold their values.
REQ-025 flush=1 SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and no done pulse.
REQ-026 flush has priority over start in the same cycle.
REQ-027 A new start is accepted in the cycle after done; back-to-back operations therefore have no dead cycle.

Reset
REQ-028 When reset_n=0, the FSM SHALL enter IDLE immediately.
REQ-029 Reset SHALL clear hi, lo, done, busy, div_by_zero, the counter and the latched operands to 0, regardless of the clock.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no done pulse follows deassertion.

Configuration
REQ-031 The macro MULDIV_SIGNED_EN SHALL control signed operation support.
REQ-032 With MULDIV_SIGNED_EN defined, MULT/DIV SHALL work on operand magnitudes.
REQ-033 The product and quotient SHALL be negated when a[31]^b[31] = 1, and the remainder SHALL take the sign of a.
REQ-034 With MULDIV_SIGNED_EN defined, DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000, hi = 0.
REQ-035 Without MULDIV_SIGNED_EN, op[0] SHALL be ignored and all operations are unsigned; no sign logic is synthesized.

Structure
REQ-036 The op encodings (muldiv_op_t enum) and the FSM state enum SHALL live in package global_types.
REQ-037 The constant MULDIV_ITER = 32 SHALL also live in global_types.
REQ-038 The single-step shift/add/subtract datapath SHALL be the sub-module muldiv_step, instantiated once and shared by multiply and divide.
REQ-039 hi and lo SHALL be built from d_en_reg instances enabled in FIN, adapted to active-low reset.

Verification
REQ-040 Scenario: reset, then MULTU a=32'hFFFF_FFFF, b=2 -> done at 34 cycles after start; hi=1, lo=32'hFFFF_FFFE.
REQ-041 Scenario: DIVU a=100, b=7 -> hi=2, lo=14, div_by_zero=0.
REQ-042 Scenario: DIV a=5, b=0 -> done 2 cycles after start; hi=5, lo=32'hFFFF_FFFF, div_by_zero=1.
REQ-043 Scenario (with MULDIV_SIGNED_EN): MULT a=-3, b=4 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF4.
REQ-044 Scenario (with MULDIV_SIGNED_EN): DIV a=-7, b=2 -> lo=-3, hi=-1.
REQ-045 Scenario: MULTU 6*7 with flush at cycle 10 -> no done pulse, hi/lo keep their previous values, and a start in the next cycle is accepted.
REQ-046 Scenario: start pulsed again during busy -> ignored.
REQ-047 Scenario: reset_n=0 mid-RUN -> all outputs 0 asynchronously, and no done pulse after release.
